// File: rtl/systolic_array_sched.sv
// rtl/systolic_array_sched.sv - job sequencer, input skew and result deskew for the 4x4 systolic PE array
// Optional feature macro: ARRAY_SCHED_PERF_EN adds the stall_cnt STREAM-bubble counter port.
module systolic_array_sched #(
   parameter int WIDTH   = 8,
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int OUT_LAT = 8,
   parameter int LEN_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      len,
   output logic                  busy,
   output logic                  done,
   input  logic                  w_valid,
   output logic                  w_ready,
   input  logic [ROWS*WIDTH-1:0] w_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [COLS*WIDTH-1:0] in_data,
   output logic [ROWS*COLS*2-1:0] arr_ctls,
   output logic [ROWS*WIDTH-1:0] arr_ws,
   output logic [COLS*WIDTH-1:0] arr_ins,
   input  logic [COLS*WIDTH-1:0] arr_outs,
   output logic                  out_valid,
   output logic [COLS*WIDTH-1:0] out_data
`ifdef ARRAY_SCHED_PERF_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int DRAIN_CYC = OUT_LAT + COLS;
   localparam int TAG_D     = OUT_LAT + COLS;
   localparam int DW        = $clog2(DRAIN_CYC + 1);
   localparam int LW        = $clog2(COLS + 1);
   localparam int CNT_W     = (LEN_W > DW) ? ((LEN_W > LW) ? LEN_W : LW)
                                           : ((DW > LW) ? DW : LW);

   localparam logic [1:0] CTL_HOLD    = 2'b00;
   localparam logic [1:0] CTL_LOAD    = 2'b01;
   localparam logic [1:0] CTL_COMPUTE = 2'b10;
   localparam logic [1:0] CTL_CLEAR   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_STREAM,
      S_DRAIN
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [LEN_W-1:0]   len_q;
   logic               done_nxt;
   logic [1:0]         ctl;
   logic               in_hs;
   logic [TAG_D-1:0]   tag_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         len_q <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
         if (state == S_IDLE && start)
            len_q <= len;
      end
   end

   // Ready signals depend only on state; ctl/arr_ws additionally follow the weight handshake.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      ctl       = CTL_HOLD;
      w_ready   = 1'b0;
      in_ready  = 1'b0;
      arr_ws    = '0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start)
               state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            ctl       = CTL_CLEAR;
            cnt_nxt   = '0;
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_ready = 1'b1;
            if (w_valid) begin
               ctl    = CTL_LOAD;
               arr_ws = w_data;
               if (cnt == CNT_W'(COLS - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = (len_q == '0) ? S_DRAIN : S_STREAM;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         S_STREAM: begin
            ctl      = CTL_COMPUTE;
            in_ready = 1'b1;
            if (in_valid) begin
               if ((cnt + CNT_W'(1)) == CNT_W'(len_q)) begin
                  cnt_nxt   = '0;
                  state_nxt = S_DRAIN;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         S_DRAIN: begin
            ctl = CTL_COMPUTE;
            if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy     = (state != S_IDLE);
   assign arr_ctls = {(ROWS*COLS){ctl}};
   assign in_hs    = in_valid && in_ready;

   // The tag line marks which deskewed slots carry accepted vectors rather than bubbles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tag_q <= '0;
      else
         tag_q <= {tag_q[TAG_D-2:0], in_hs};
   end

   assign out_valid = tag_q[TAG_D-1];

   for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [WIDTH-1:0] skew_q [0:c];
      logic [WIDTH-1:0] desk_col;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int k = 0; k <= c; k++)
               skew_q[k] <= '0;
         end else begin
            skew_q[0] <= in_hs ? in_data[c*WIDTH +: WIDTH] : '0;
            for (int k = 1; k <= c; k++)
               skew_q[k] <= skew_q[k-1];
         end
      end

      assign arr_ins[c*WIDTH +: WIDTH] = skew_q[c];

      if (COLS - 1 - c == 0) begin : g_direct
         assign desk_col = arr_outs[c*WIDTH +: WIDTH];
      end else begin : g_dly
         logic [WIDTH-1:0] dsk_q [0:COLS-2-c];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k <= COLS - 2 - c; k++)
                  dsk_q[k] <= '0;
            end else begin
               dsk_q[0] <= arr_outs[c*WIDTH +: WIDTH];
               for (int k = 1; k <= COLS - 2 - c; k++)
                  dsk_q[k] <= dsk_q[k-1];
            end
         end

         assign desk_col = dsk_q[COLS-2-c];
      end

      assign out_data[c*WIDTH +: WIDTH] = out_valid ? desk_col : '0;
   end

`ifdef ARRAY_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (state == S_IDLE && start)
         stall_cnt <= '0;
      else if (state == S_STREAM && !in_valid && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_systolic_array_sched.sv
// tb/tb_systolic_array_sched.sv - scoreboard bench for systolic_array_sched with a pure-delay array model
module tb_systolic_array_sched;

   localparam int WIDTH   = 8;
   localparam int ROWS    = 4;
   localparam int COLS    = 4;
   localparam int OUT_LAT = 8;
   localparam int LEN_W   = 8;
   localparam int LAT     = OUT_LAT + COLS;

   localparam logic [31:0] CTL_HOLD_ALL = 32'h0000_0000;
   localparam logic [31:0] CTL_LOAD_ALL = 32'h5555_5555;
   localparam logic [31:0] CTL_COMP_ALL = 32'hAAAA_AAAA;
   localparam logic [31:0] CTL_CLR_ALL  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start, busy, done;
   logic [7:0]  len;
   logic        w_valid, w_ready, in_valid, in_ready, out_valid;
   logic [31:0] w_data, in_data, arr_ws, arr_ins, arr_outs, out_data, arr_ctls;
`ifdef ARRAY_SCHED_PERF_EN
   logic [15:0] stall_cnt;
`endif

   systolic_array_sched #(
      .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .OUT_LAT(OUT_LAT), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .arr_ctls(arr_ctls), .arr_ws(arr_ws), .arr_ins(arr_ins), .arr_outs(arr_outs),
      .out_valid(out_valid), .out_data(out_data)
`ifdef ARRAY_SCHED_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int          t;
      logic [31:0] d;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         sb_e;
   logic [31:0] hist [4];
   logic [31:0] exp_ins;
   logic [31:0] apipe [OUT_LAT];
   logic [31:0] vtab [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Array stand-in: each column result is its operand, OUT_LAT cycles later.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < OUT_LAT; i++) apipe[i] <= '0;
      end else begin
         apipe[0] <= arr_ins;
         for (int i = 1; i < OUT_LAT; i++) apipe[i] <= apipe[i-1];
      end
   end
   assign arr_outs = apipe[OUT_LAT-1];

   // Stimulus side: every accepted vector becomes an expected result.
   always @(negedge clk) begin
      if (rst && in_valid && in_ready)
         sb_q.push_back('{cyc, in_data});
   end

   // Monitor: skewed column feed, then in-order results at fixed latency.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) hist[i] = '0;
      end else begin
         for (int c = 0; c < COLS; c++) exp_ins[c*8 +: 8] = hist[c][c*8 +: 8];
         check("arr_ins_skew", arr_ins, exp_ins);
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = (in_valid && in_ready) ? in_data : 32'h0;
         if (out_valid) begin
            check("out_valid_expected", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               sb_e = sb_q.pop_front();
               check("out_data", out_data, sb_e.d);
               check("out_latency", cyc - sb_e.t, LAT);
            end
         end else begin
            check("out_data_idle", out_data, 0);
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_w_ready"}, w_ready, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_arr_ctls"}, arr_ctls, 0);
      check({tag, "_arr_ws"}, arr_ws, 0);
      check({tag, "_arr_ins"}, arr_ins, 0);
      check({tag, "_out_data"}, out_data, 0);
`ifdef ARRAY_SCHED_PERF_EN
      check({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
   endtask

   // Entered and left at 1 time unit after a rising edge with the FSM idle.
   task automatic run_job(input int n, input logic [31:0] wmask, input logic [31:0] imask,
                          input int exp_stalls, input int vbase, input bit poke);
      int nh, ni, k, d;
      start = 1'b1;
      len   = 8'(n);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_ctl", arr_ctls, CTL_HOLD_ALL);
      @(posedge clk); #1;
      start = 1'b0;
      len   = 8'hA5;
      @(negedge clk);
      check("clear_ctl", arr_ctls, CTL_CLR_ALL);
      check("clear_busy", busy, 1);
      check("clear_w_ready", w_ready, 0);
`ifdef ARRAY_SCHED_PERF_EN
      check("stall_cleared", stall_cnt, 0);
`endif
      nh = 0;
      k  = 0;
      while (nh < COLS && k < 40) begin
         @(posedge clk); #1;
         if (poke) begin
            start = 1'b1;
            len   = 8'hFF;
         end
         w_valid = wmask[k % 32];
         w_data  = 32'h1020_3040 + 32'(nh) * 32'h0101_0101;
         @(negedge clk);
         check("load_w_ready", w_ready, 1);
         if (w_valid) begin
            check("load_ctl", arr_ctls, CTL_LOAD_ALL);
            check("load_ws", arr_ws, w_data);
            nh++;
         end else begin
            check("hold_ctl", arr_ctls, CTL_HOLD_ALL);
            check("hold_ws", arr_ws, 0);
         end
         k++;
      end
      check("load_handshakes", nh, COLS);
      @(posedge clk); #1;
      w_valid = 1'b0;
      w_data  = '0;
      ni = 0;
      k  = 0;
      while (ni < n && k < 60) begin
         in_valid = imask[k % 32];
         in_data  = vtab[(vbase + ni) % 8];
         @(negedge clk);
         check("stream_ctl", arr_ctls, CTL_COMP_ALL);
         check("stream_in_ready", in_ready, 1);
         check("stream_w_ready", w_ready, 0);
         if (in_valid) ni++;
         k++;
         @(posedge clk); #1;
      end
      check("stream_accepted", ni, n);
      in_valid = 1'b0;
      in_data  = '0;
      start    = 1'b0;
      d = 0;
      @(negedge clk);
      while (!done && d < 40) begin
         check("drain_ctl", arr_ctls, CTL_COMP_ALL);
         check("drain_in_ready", in_ready, 0);
         check("drain_busy", busy, 1);
         d++;
         @(posedge clk); #1;
         @(negedge clk);
      end
      check("drain_cycles", d, LAT);
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_ctl", arr_ctls, CTL_HOLD_ALL);
      check("results_all_out", sb_q.size(), 0);
`ifdef ARRAY_SCHED_PERF_EN
      check("stall_cnt", stall_cnt, exp_stalls);
`endif
      @(posedge clk); #1;
      @(negedge clk);
      check("done_single", done, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int ni, k;
      vtab = '{32'h0403_0201, 32'h80FF_7F10, 32'h1234_5678, 32'hDEAD_BEEF,
               32'h0F0E_0D0C, 32'hA5A5_5A5A, 32'h1122_3344, 32'hC0FF_EE00};
      start = 0; len = 0; w_valid = 0; w_data = 0; in_valid = 0; in_data = 0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      run_job(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
      run_job(2, 32'hFFFF_FFFF, 32'h0000_0009, 2, 4, 1'b0);
      run_job(3, 32'h0000_01C1, 32'hFFFF_FFFF, 0, 1, 1'b0);
      run_job(5, 32'hFFFF_FFFF, 32'h0000_0155, 4, 2, 1'b0);
      run_job(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1);
      run_job(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5, 1'b1);

      // Abort a len=8 job after its third accepted vector.
      start = 1'b1;
      len   = 8'd8;
      @(posedge clk); #1;
      start    = 1'b0;
      len      = 8'h00;
      w_valid  = 1'b1;
      w_data   = 32'h0102_0304;
      in_valid = 1'b1;
      in_data  = vtab[3];
      ni = 0;
      k  = 0;
      while (ni < 3 && k < 30) begin
         @(negedge clk);
         if (in_valid && in_ready) ni++;
         k++;
         @(posedge clk); #1;
      end
      check("abort_pre_accepted", ni, 3);
      rst = 1'b0;
      #1;
      check_zero("abort");
      sb_q.delete();
      w_valid  = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
         check("abort_idle", busy, 0);
         check("abort_no_out", out_valid, 0);
         @(posedge clk); #1;
      end

      run_job(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 6, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
